// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder walks two WIDTH-bit operands
// LSB-first, one bit per clock, carry held in a flop between bits.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_c;

    fulladder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (c_q),
        .s_o  (fa_s),
        .co_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d   = {fa_s, s_q[WIDTH-1:1]};
                c_d   = fa_c;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the result straight from the adder.
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, s_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=5 against an
// arithmetic reference model.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start5, cin5, busy5, done5, cout5;
    logic [4:0] a5, b5, sum5;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5),
        .a_in(a5), .b_in(b5), .cin(cin5),
        .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
    );

    function automatic logic [8:0] ref8(logic [7:0] a, logic [7:0] b, logic c);
        int r;
        r = int'(a) + int'(b) + int'(c);
        return 9'(r);
    endfunction

    function automatic logic [5:0] ref5(logic [4:0] a, logic [4:0] b, logic c);
        int r;
        r = int'(a) + int'(b) + int'(c);
        return 6'(r);
    endfunction

    task automatic issue8(logic [7:0] a, logic [7:0] b, logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    endtask

    // Returns negedges after the issuing negedge until done8, -1 on timeout.
    task automatic wait_done8(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                cyc = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_init: got %h want 000", {busy8, done8, cout8, sum8});
        end
        @(negedge clk);
        rst = 1'b0;
        issue8(8'hC3, 8'h5D, 1'b1);
        wait_done8(cyc);
        nvec++;
        if (cyc != 8 + 1 || {cout8, sum8} !== ref8(8'hC3, 8'h5D, 1'b1)) begin
            nerr++;
            $display("FAIL reset_release_op: cyc %0d res %h want 9 %h",
                     cyc, {cout8, sum8}, ref8(8'hC3, 8'h5D, 1'b1));
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_async: got %h want 000", {busy8, done8, cout8, sum8});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [8:0] ve [3];
        int cyc;
        va = '{8'hFF, 8'h7F, 8'hA5};
        vb = '{8'h01, 8'h01, 8'h5A};
        vc = '{1'b0, 1'b0, 1'b1};
        ve = '{9'h100, 9'h080, 9'h100};
        for (int i = 0; i < 3; i++) begin
            issue8(va[i], vb[i], vc[i]);
            wait_done8(cyc);
            nvec++;
            if (cyc != 9) begin
                nerr++;
                $display("FAIL basic_latency[%0d]: got %0d want 9", i, cyc);
            end
            nvec++;
            if ({cout8, sum8} !== ve[i]) begin
                nerr++;
                $display("FAIL basic_result[%0d]: got %h want %h", i, {cout8, sum8}, ve[i]);
            end
            @(negedge clk);
            nvec++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== ve[i]) begin
                nerr++;
                $display("FAIL basic_after[%0d]: done %b busy %b res %h want 0 0 %h",
                         i, done8, busy8, {cout8, sum8}, ve[i]);
            end
        end
    endtask

    task automatic test_start_during_run();
        int ndone = 0;
        int at = -1;
        logic [8:0] e;
        e = ref8(8'h3C, 8'h41, 1'b0);
        issue8(8'h3C, 8'h41, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                at = k;
                nvec++;
                if ({cout8, sum8} !== e) begin
                    nerr++;
                    $display("FAIL ignore_start_result: got %h want %h", {cout8, sum8}, e);
                end
            end
            if (k == 3 || k == 7) issue8(8'($urandom), 8'($urandom), 1'b1);
            else start8 = 1'b0;
        end
        nvec++;
        if (ndone != 1 || at != 9) begin
            nerr++;
            $display("FAIL ignore_start_done: got %0d at %0d want 1 at 9", ndone, at);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q [$];
        logic [8:0] last;
        logic [7:0] a, b;
        logic       c;
        int ndone = 0;
        int since = 0;
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
        q.push_back(ref8(a, b, c));
        issue8(a, b, c);
        last = {cout8, sum8};
        for (int k = 1; k <= 80 && ndone < 5; k++) begin
            @(negedge clk);
            since++;
            if (done8) begin
                ndone++;
                nvec++;
                if (since != 9 || {cout8, sum8} !== q[0]) begin
                    nerr++;
                    $display("FAIL b2b[%0d]: period %0d res %h want 9 %h",
                             ndone, since, {cout8, sum8}, q[0]);
                end
                last = q.pop_front();
                since = 0;
                a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
                q.push_back(ref8(a, b, c));
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                nvec++;
                if ({cout8, sum8} !== last) begin
                    nerr++;
                    $display("FAIL b2b_hold: got %h want %h", {cout8, sum8}, last);
                end
            end
            if (since == 0) issue8(a, b, c);
        end
        nvec++;
        if (ndone != 5) begin
            nerr++;
            $display("FAIL b2b_count: got %0d want 5", ndone);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int cyc;
        issue8(8'h55, 8'h66, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_mid_outputs: got %h want 000", {busy8, done8, cout8, sum8});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        nvec++;
        if (nd != 0 || {cout8, sum8} !== 9'd0) begin
            nerr++;
            $display("FAIL reset_mid_abort: dones %0d res %h want 0 000", nd, {cout8, sum8});
        end
        issue8(8'h03, 8'h04, 1'b0);
        wait_done8(cyc);
        nvec++;
        if (cyc != 9 || {cout8, sum8} !== 9'h007) begin
            nerr++;
            $display("FAIL reset_mid_next: cyc %0d res %h want 9 007", cyc, {cout8, sum8});
        end
    endtask

    task automatic test_random();
        logic [8:0] e8;
        logic [5:0] e5;
        int g8, g5;
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
            e8 = ref8(a8, b8, cin8);
            e5 = ref5(a5, b5, cin5);
            start8 = 1'b1; start5 = 1'b1;
            g8 = 0; g5 = 0;
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                start8 = 1'b0; start5 = 1'b0;
                if (k == 1) begin
                    a8 = ~a8; b8 = ~b8; a5 = ~a5; b5 = ~b5;
                end
                if (done8) begin
                    g8++;
                    nvec++;
                    if (k != 9 || {cout8, sum8} !== e8) begin
                        nerr++;
                        $display("FAIL rand8[%0d]: cyc %0d res %h want 9 %h",
                                 n, k, {cout8, sum8}, e8);
                    end
                end
                if (done5) begin
                    g5++;
                    nvec++;
                    if (k != 6 || {cout5, sum5} !== e5) begin
                        nerr++;
                        $display("FAIL rand5[%0d]: cyc %0d res %h want 6 %h",
                                 n, k, {cout5, sum5}, e5);
                    end
                end
            end
            nvec++;
            if (g8 != 1 || g5 != 1) begin
                nerr++;
                $display("FAIL rand_done_count[%0d]: w8 %0d w5 %0d want 1 1", n, g8, g5);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
        #1 rst = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
